ysyx_24110006_mem_arb: RTL

Two-master, one-slave memory arbiter. It shares the single core memory port between the IFU (instruction fetch, read-only) and the LSU, which carries the EXU's mem_ren/mem_wen/wmask/addr/wdata.
- At most one transaction is outstanding at a time, with a 3-state sequencer: accept, issue, response.
- Response is routed back to the granting master.
- Sits between IFU/LSU and the bus bridge.

---
 rtl/ysyx_24110006_mem_arb.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_24110006_mem_arb.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_mem_arb
//
// Two-master / one-slave memory arbiter. The instruction fetch unit (IFU,
// read-only) and the load/store unit (LSU) share the single core memory port.
// At most one transaction is outstanding. A three-state sequencer handles it:
//   IDLE : pick a master, accept its request, and latch the request fields.
//   REQ  : present the latched request until the slave takes it.
//   RESP : wait for the slave response and route it to the granted master.
//
// Handshake rules (all interfaces):
//   A request transfers on a cycle where valid && ready are both high at the
//   rising edge of i_clock. A requester may drop valid without having seen
//   ready; the arbiter then ignores that request. Responses have no
//   back-pressure. o_ifu_rvalid and o_lsu_rvalid are one-cycle strobes that
//   the master must consume. rdata and err are meaningful only while the
//   matching rvalid is high.
//
// Timing: accept at t, o_mem_valid at t+1, earliest response at t+2, and the
// next accept at t+3 at the earliest.
//
// Pipeline flush: i_flush while an IFU transaction is in REQ or RESP marks
// the transaction as dropped. The bus transaction still completes, and the
// response is consumed, but it is not delivered to the IFU. i_flush has no
// effect in IDLE and no effect on LSU transactions.
//
// Optional build macro:
//   MEM_ARB_RR_EN  round-robin grant between the masters. When it is
//                  undefined, the LSU has fixed priority over the IFU.
//
// Ports:
//   i_clock, i_reset             clock; synchronous active-low reset
//   i_ifu_*, o_ifu_*             IFU request and response
//   i_lsu_*, o_lsu_*             LSU request and response
//   i_flush                      pipeline redirect (cancels the IFU response)
//   o_mem_*, i_mem_*             downstream port toward the bus bridge
//   o_busy                       high whenever the sequencer is not in IDLE
//   o_dbg_state                  current sequencer state (0 IDLE, 1 REQ, 2 RESP)
// ---------------------------------------------------------------------------
module ysyx_24110006_mem_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,

  input  logic                  i_ifu_valid,
  input  logic [ADDR_W-1:0]     i_ifu_addr,
  output logic                  o_ifu_ready,
  output logic                  o_ifu_rvalid,
  output logic [DATA_W-1:0]     o_ifu_rdata,
  output logic                  o_ifu_err,

  input  logic                  i_lsu_valid,
  input  logic [ADDR_W-1:0]     i_lsu_addr,
  input  logic                  i_lsu_wen,
  input  logic [DATA_W-1:0]     i_lsu_wdata,
  input  logic [DATA_W/8-1:0]   i_lsu_wmask,
  output logic                  o_lsu_ready,
  output logic                  o_lsu_rvalid,
  output logic [DATA_W-1:0]     o_lsu_rdata,
  output logic                  o_lsu_err,

  input  logic                  i_flush,

  output logic                  o_mem_valid,
  input  logic                  i_mem_ready,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic                  o_mem_wen,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_wmask,
  input  logic                  i_mem_rvalid,
  output logic                  o_mem_rready,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  input  logic                  i_mem_err,

  output logic                  o_busy,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic GRANT_IFU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  state_t state_q;
  logic   grant_q;   // master that owns the in-flight transaction
  logic   drop_q;    // IFU response must not be delivered (flushed)

`ifdef MEM_ARB_RR_EN
  logic   last_q;    // master granted at the most recent accept
`endif

  logic   pick_lsu;
  logic   pick_ifu;
  logic   in_idle;
  logic   accept;
  logic   resp_fire;

  // Grant selection. This only matters while the sequencer is in IDLE.
  always_comb begin
    pick_lsu = 1'b0;
    pick_ifu = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (i_lsu_valid && i_ifu_valid) begin
      // Under contention, the master that was not served last wins.
      pick_lsu = (last_q == GRANT_IFU);
      pick_ifu = (last_q == GRANT_LSU);
    end else begin
      pick_lsu = i_lsu_valid;
      pick_ifu = i_ifu_valid;
    end
`else
    pick_lsu = i_lsu_valid;
    pick_ifu = i_ifu_valid && !i_lsu_valid;
`endif
  end

  // Every combinational strobe is qualified with i_reset, so nothing
  // handshakes during a cycle that will be discarded by reset anyway.
  assign in_idle      = i_reset && (state_q == S_IDLE);
  assign o_lsu_ready  = in_idle && pick_lsu;
  assign o_ifu_ready  = in_idle && pick_ifu;
  assign accept       = o_lsu_ready || o_ifu_ready;

  assign o_mem_rready = i_reset && (state_q == S_RESP);
  assign resp_fire    = o_mem_rready && i_mem_rvalid;

  // A flush that arrives in the same cycle as the response also cancels
  // delivery. Without this, that response would slip through before drop_q
  // could register the flush.
  assign o_ifu_rvalid = resp_fire && (grant_q == GRANT_IFU) && !drop_q && !i_flush;
  assign o_lsu_rvalid = resp_fire && (grant_q == GRANT_LSU);

  assign o_ifu_rdata  = i_mem_rdata;
  assign o_ifu_err    = i_mem_err;
  assign o_lsu_rdata  = i_mem_rdata;
  assign o_lsu_err    = i_mem_err;

  assign o_dbg_state  = state_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      grant_q     <= GRANT_IFU;
      drop_q      <= 1'b0;
      o_mem_valid <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wen   <= 1'b0;
      o_mem_wdata <= '0;
      o_mem_wmask <= '0;
      o_busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q      <= GRANT_IFU;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q     <= S_REQ;
            o_mem_valid <= 1'b1;
            o_busy      <= 1'b1;
            drop_q      <= 1'b0;
            if (pick_lsu) begin
              grant_q     <= GRANT_LSU;
              o_mem_addr  <= i_lsu_addr;
              o_mem_wen   <= i_lsu_wen;
              o_mem_wdata <= i_lsu_wdata;
              // Loads carry no byte strobes downstream.
              o_mem_wmask <= i_lsu_wen ? i_lsu_wmask : '0;
            end else begin
              grant_q     <= GRANT_IFU;
              o_mem_addr  <= i_ifu_addr;
              o_mem_wen   <= 1'b0;
              o_mem_wdata <= '0;
              o_mem_wmask <= '0;
            end
`ifdef MEM_ARB_RR_EN
            last_q <= pick_lsu ? GRANT_LSU : GRANT_IFU;
`endif
          end
        end

        S_REQ: begin
          if (i_flush && (grant_q == GRANT_IFU)) begin
            drop_q <= 1'b1;
          end
          // Any rvalid seen here is ignored: the slave may not respond
          // before it has accepted the request.
          if (i_mem_ready) begin
            state_q     <= S_RESP;
            o_mem_valid <= 1'b0;
          end
        end

        S_RESP: begin
          if (i_mem_rvalid) begin
            state_q <= S_IDLE;
            o_busy  <= 1'b0;
            drop_q  <= 1'b0;
          end else if (i_flush && (grant_q == GRANT_IFU)) begin
            drop_q <= 1'b1;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          o_mem_valid <= 1'b0;
          o_busy      <= 1'b0;
          drop_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
